// File: rtl/wb_machine_timer.sv
// RISC-V machine timer (mtime/mtimecmp) and software interrupt (msip) as a
// pipelined Wishbone B4 slave with one cycle of latency and a tear-free mtime read.
module wb_machine_timer #(
    parameter int          PRESC_WIDTH    = 8,
    parameter bit          RESET_EN       = 1'b1,
    parameter logic [63:0] MTIMECMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    input  logic [3:0]  wb_sel_i,
    output logic        wb_stall_o,
    output logic        wb_ack_o,
    output logic [31:0] wb_dat_o,
    output logic        wb_err_o,
    output logic        mtip_o,
    output logic        msip_o
);

    localparam logic [2:0] OFF_MTIME_LO = 3'd0;
    localparam logic [2:0] OFF_MTIME_HI = 3'd1;
    localparam logic [2:0] OFF_CMP_LO   = 3'd2;
    localparam logic [2:0] OFF_CMP_HI   = 3'd3;
    localparam logic [2:0] OFF_CTRL     = 3'd4;
    localparam logic [2:0] OFF_MSIP     = 3'd5;

    logic [63:0]            mtime_q, mtime_d;
    logic [31:0]            shadow_q, shadow_d;
    logic [63:0]            cmp_q, cmp_d;
    logic                   en_q, en_d;
    logic [PRESC_WIDTH-1:0] presc_q, presc_d;
    logic [PRESC_WIDTH-1:0] pcnt_q, pcnt_d;
    logic                   msip_q, msip_d;
    logic                   ack_q, ack_d;
    logic                   err_q, err_d;
    logic [31:0]            dat_q, dat_d;
    logic                   mtip_q, mtip_d;

    logic        req, wr, rd, mapped, tick;
    logic [2:0]  off;
    logic [31:0] ctrl_rd, rd_data, ctrl_wr;

    logic unused_adr_bits;
    assign unused_adr_bits = &{1'b0, wb_adr_i[31:5], wb_adr_i[1:0]};

    function automatic logic [31:0] merge(input logic [31:0] old_v,
                                          input logic [31:0] new_v,
                                          input logic [3:0]  sel);
        logic [31:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) r[8*b +: 8] = new_v[8*b +: 8];
        end
        return r;
    endfunction

    assign req    = wb_cyc_i & wb_stb_i;
    assign wr     = req & wb_we_i;
    assign rd     = req & ~wb_we_i;
    assign off    = wb_adr_i[4:2];
    assign mapped = (off <= OFF_MSIP);
    assign tick   = en_q && (pcnt_q == presc_q);

    always_comb begin
        ctrl_rd                    = '0;
        ctrl_rd[0]                 = en_q;
        ctrl_rd[8 +: PRESC_WIDTH]  = presc_q;
    end

    assign ctrl_wr = merge(ctrl_rd, wb_dat_i, wb_sel_i);

    always_comb begin
        rd_data = '0;
        case (off)
            OFF_MTIME_LO: rd_data = mtime_q[31:0];
            OFF_MTIME_HI: rd_data = shadow_q;
            OFF_CMP_LO:   rd_data = cmp_q[31:0];
            OFF_CMP_HI:   rd_data = cmp_q[63:32];
            OFF_CTRL:     rd_data = ctrl_rd;
            OFF_MSIP:     rd_data = {31'b0, msip_q};
            default:      rd_data = '0;
        endcase
    end

    always_comb begin
        mtime_d  = tick ? mtime_q + 64'd1 : mtime_q;
        pcnt_d   = pcnt_q;
        shadow_d = shadow_q;
        cmp_d    = cmp_q;
        en_d     = en_q;
        presc_d  = presc_q;
        msip_d   = msip_q;
        if (en_q) pcnt_d = tick ? '0 : pcnt_q + 1'b1;

        // mtime writes start from the pre-tick value so a coincident tick is dropped
        if (wr) begin
            case (off)
                OFF_MTIME_LO: mtime_d = {mtime_q[63:32], merge(mtime_q[31:0], wb_dat_i, wb_sel_i)};
                OFF_MTIME_HI: begin
                    mtime_d  = {merge(mtime_q[63:32], wb_dat_i, wb_sel_i), mtime_q[31:0]};
                    shadow_d = merge(mtime_q[63:32], wb_dat_i, wb_sel_i);
                end
                OFF_CMP_LO:   cmp_d = {cmp_q[63:32], merge(cmp_q[31:0], wb_dat_i, wb_sel_i)};
                OFF_CMP_HI:   cmp_d = {merge(cmp_q[63:32], wb_dat_i, wb_sel_i), cmp_q[31:0]};
                OFF_CTRL: begin
                    en_d    = ctrl_wr[0];
                    presc_d = ctrl_wr[8 +: PRESC_WIDTH];
                    pcnt_d  = '0;
                end
                OFF_MSIP:     msip_d = wb_sel_i[0] ? wb_dat_i[0] : msip_q;
                default: ;
            endcase
        end
        if (rd && off == OFF_MTIME_LO) shadow_d = mtime_q[63:32];

        ack_d  = req & mapped;
        err_d  = req & ~mapped;
        dat_d  = (rd & mapped) ? rd_data : '0;
        mtip_d = (mtime_q >= cmp_q);
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            mtime_q  <= '0;
            shadow_q <= '0;
            cmp_q    <= MTIMECMP_RESET;
            en_q     <= RESET_EN;
            presc_q  <= '0;
            pcnt_q   <= '0;
            msip_q   <= 1'b0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            dat_q    <= '0;
            mtip_q   <= 1'b0;
        end else begin
            mtime_q  <= mtime_d;
            shadow_q <= shadow_d;
            cmp_q    <= cmp_d;
            en_q     <= en_d;
            presc_q  <= presc_d;
            pcnt_q   <= pcnt_d;
            msip_q   <= msip_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
            dat_q    <= dat_d;
            mtip_q   <= mtip_d;
        end
    end

    // A master that abandons the cycle gets no response; writes have already landed
    assign wb_stall_o = 1'b0;
    assign wb_ack_o   = ack_q & wb_cyc_i;
    assign wb_err_o   = err_q & wb_cyc_i;
    assign wb_dat_o   = wb_ack_o ? dat_q : 32'd0;
    assign mtip_o     = mtip_q;
    assign msip_o     = msip_q;

endmodule

// File: tb/tb_wb_machine_timer.sv
// Directed bench for wb_machine_timer: counting, prescaler, wrap/shadow,
// compare interrupt, msip, error offsets, burst acks and asynchronous reset.
module tb_wb_machine_timer;

    localparam logic [2:0] MT_LO = 3'd0, MT_HI = 3'd1, CMP_LO = 3'd2, CMP_HI = 3'd3,
                           CTRL = 3'd4, MSIP = 3'd5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [31:0] adr = '0, dat_i = '0;
    logic [3:0]  sel = '0;
    logic        stall_o, ack_o, err_o, mtip_o, msip_o;
    logic [31:0] dat_o;

    int tests = 0;
    int fails = 0;

    wb_machine_timer dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .wb_cyc_i  (cyc),
        .wb_stb_i  (stb),
        .wb_we_i   (we),
        .wb_adr_i  (adr),
        .wb_dat_i  (dat_i),
        .wb_sel_i  (sel),
        .wb_stall_o(stall_o),
        .wb_ack_o  (ack_o),
        .wb_dat_o  (dat_o),
        .wb_err_o  (err_o),
        .mtip_o    (mtip_o),
        .msip_o    (msip_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; request accepted at the next posedge, response sampled at the following negedge.
    task automatic xfer(input logic w, input logic [2:0] off, input logic [31:0] d,
                        input logic [3:0] s, output logic [31:0] r, output logic a, output logic e);
        cyc = 1'b1; stb = 1'b1; we = w; adr = {27'b0, off, 2'b00}; dat_i = d; sel = s;
        @(posedge clk);
        @(negedge clk);
        r = dat_o; a = ack_o; e = err_o;
        $display("[TB] %s off=%0d dat_i=%h sel=%b -> ack=%b err=%b dat_o=%h",
                 w ? "WR" : "RD", off, d, s, a, e, r);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic wr(input string tag, input logic [2:0] off, input logic [31:0] d);
        logic [31:0] r; logic a, e;
        xfer(1'b1, off, d, 4'hF, r, a, e);
        check({tag, "_ack"}, {31'b0, a}, 32'd1);
    endtask

    task automatic rd(input string tag, input logic [2:0] off, input logic [31:0] exp);
        logic [31:0] r; logic a, e;
        xfer(1'b0, off, 32'd0, 4'hF, r, a, e);
        check(tag, r, exp);
        check({tag, "_ack"}, {31'b0, a}, 32'd1);
    endtask

    initial begin
        logic [31:0] r;
        logic a, e, bad;

        // Reset state
        #2;
        check("rst_ack", {31'b0, ack_o}, 32'd0);
        check("rst_err", {31'b0, err_o}, 32'd0);
        check("rst_dat", dat_o, 32'd0);
        check("rst_mtip", {31'b0, mtip_o}, 32'd0);
        check("rst_msip", {31'b0, msip_o}, 32'd0);
        check("stall", {31'b0, stall_o}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // 1: free run at presc=0 for 100 cycles, mtip stays low
        bad = 1'b0;
        repeat (100) begin
            @(negedge clk);
            if (mtip_o !== 1'b0) bad = 1'b1;
        end
        check("t1_mtip_low", {31'b0, bad}, 32'd0);
        rd("t1_mtime_100", MT_LO, 32'd100);
        rd("t1_ctrl_rst", CTRL, 32'h0000_0001);
        rd("t1_cmp_lo_rst", CMP_LO, 32'hFFFF_FFFF);
        rd("t1_cmp_hi_rst", CMP_HI, 32'hFFFF_FFFF);
        rd("t1_msip_rst", MSIP, 32'd0);

        // 2: prescaler 3 -> one tick per 4 cycles, then freeze
        wr("t2_wr_hi", MT_HI, 32'd0);
        wr("t2_wr_lo", MT_LO, 32'd0);
        wr("t2_wr_ctrl", CTRL, 32'h0000_0301);
        for (int i = 0; i < 9; i++) rd($sformatf("t2_presc_rd%0d", i), MT_LO, 32'(1 + i / 4));
        wr("t2_disable", CTRL, 32'd0);
        rd("t2_frozen_a", MT_LO, 32'd3);
        repeat (5) @(negedge clk);
        rd("t2_frozen_b", MT_LO, 32'd3);
        rd("t2_ctrl_zero", CTRL, 32'd0);

        // 3: wrap of 2^64-1 and shadowed high word across the carry
        wr("t3_wr_hi", MT_HI, 32'hFFFF_FFFF);
        wr("t3_wr_lo", MT_LO, 32'hFFFF_FFFE);
        wr("t3_enable", CTRL, 32'h0000_0001);
        rd("t3_lo_fffe", MT_LO, 32'hFFFF_FFFE);
        rd("t3_lo_ffff", MT_LO, 32'hFFFF_FFFF);
        rd("t3_hi_shadow", MT_HI, 32'hFFFF_FFFF);
        rd("t3_lo_wrapped", MT_LO, 32'd1);
        rd("t3_hi_wrapped", MT_HI, 32'd0);

        // 4: compare at 0x40
        wr("t4_disable", CTRL, 32'd0);
        wr("t4_lo0", MT_LO, 32'd0);
        wr("t4_hi0", MT_HI, 32'd0);
        wr("t4_cmphi0", CMP_HI, 32'd0);
        wr("t4_cmplo40", CMP_LO, 32'h40);
        check("t4_mtip_idle", {31'b0, mtip_o}, 32'd0);
        wr("t4_enable", CTRL, 32'h0000_0001);
        repeat (64) @(negedge clk);
        check("t4_mtip_at_eq", {31'b0, mtip_o}, 32'd0);
        @(negedge clk);
        check("t4_mtip_rise", {31'b0, mtip_o}, 32'd1);
        wr("t4_cmphi_max", CMP_HI, 32'hFFFF_FFFF);
        check("t4_mtip_lag", {31'b0, mtip_o}, 32'd1);
        @(negedge clk);
        check("t4_mtip_fall", {31'b0, mtip_o}, 32'd0);

        // 5: msip byte lanes, unmapped offsets, cyc dropped before response
        xfer(1'b1, MSIP, 32'd1, 4'b0001, r, a, e);
        check("t5_msip_ack", {31'b0, a}, 32'd1);
        check("t5_msip_set", {31'b0, msip_o}, 32'd1);
        xfer(1'b1, MSIP, 32'd0, 4'b0010, r, a, e);
        check("t5_msip_ack2", {31'b0, a}, 32'd1);
        check("t5_msip_kept", {31'b0, msip_o}, 32'd1);
        rd("t5_msip_rd", MSIP, 32'd1);
        xfer(1'b0, 3'd6, 32'd0, 4'hF, r, a, e);
        check("t5_err6", {31'b0, e}, 32'd1);
        check("t5_err6_ack", {31'b0, a}, 32'd0);
        check("t5_err6_dat", r, 32'd0);
        xfer(1'b1, 3'd7, 32'hFFFF_FFFF, 4'hF, r, a, e);
        check("t5_err7", {31'b0, e}, 32'd1);
        check("t5_err7_ack", {31'b0, a}, 32'd0);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = {27'b0, MSIP, 2'b00}; dat_i = 32'd0; sel = 4'b0001;
        @(posedge clk);
        #1 cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(negedge clk);
        check("t5_nocyc_ack", {31'b0, ack_o}, 32'd0);
        check("t5_nocyc_commit", {31'b0, msip_o}, 32'd0);

        // 6: back-to-back reads, then asynchronous reset mid-burst
        wr("t6_cmphi0", CMP_HI, 32'd0);
        wr("t6_msip1", MSIP, 32'd1);
        rd("t6_b0", CMP_LO, 32'h40);
        rd("t6_b1", CMP_HI, 32'd0);
        rd("t6_b2", CTRL, 32'h0000_0001);
        rd("t6_b3", MSIP, 32'd1);
        check("t6_mtip_pre", {31'b0, mtip_o}, 32'd1);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = {27'b0, CMP_LO, 2'b00};
        @(posedge clk);
        #1;
        check("t6_ack_pending", {31'b0, ack_o}, 32'd1);
        rst = 1'b1;
        #1;
        check("t6_rst_ack", {31'b0, ack_o}, 32'd0);
        check("t6_rst_err", {31'b0, err_o}, 32'd0);
        check("t6_rst_dat", dat_o, 32'd0);
        check("t6_rst_mtip", {31'b0, mtip_o}, 32'd0);
        check("t6_rst_msip", {31'b0, msip_o}, 32'd0);
        cyc = 1'b0; stb = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        rd("t6_mtime_rst", MT_LO, 32'd0);
        rd("t6_shadow_rst", MT_HI, 32'd0);
        rd("t6_cmplo_rst", CMP_LO, 32'hFFFF_FFFF);
        rd("t6_cmphi_rst", CMP_HI, 32'hFFFF_FFFF);
        rd("t6_ctrl_rst", CTRL, 32'h0000_0001);
        rd("t6_msip_rst", MSIP, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
